mux_scan_controller: RTL and testbench
======================================

// Module: mux_scan_controller
// PURPOSE
//  Sequences a latched N-input mux (registered sel, registered dout, 2-cycle sel->dout latency)
//  through the enabled channels of a mask, round-robin, with per-channel settle and dwell time.
//  Drives the mux sel/clken and tags the mux output with valid and chan_id for downstream capture.
//  Sits between the config registers and the acquisition path.
// PARAMETERS
//  N_INPUTS      3   number of mux inputs (channels)
//  SEL_WIDTH     2   width of sel/chan_id; 2**SEL_WIDTH >= N_INPUTS
//  DWELL_WIDTH   16  width of dwell counter
//  SETTLE_CYCLES 1   extra cycles after mux latency before valid; must be >= 1
// PORTS
//  clk         in  1            single clock
//  resetn      in  1            synchronous active-low reset
//  start       in  1            pulse: latch config and begin scan (ignored when busy)
//  stop        in  1            abort the scan; return to IDLE
//  continuous  in  1            1: wrap forever; 0: one sweep then IDLE
//  enable_mask in  N_INPUTS     bit i = scan channel i
//  dwell       in  DWELL_WIDTH  valid cycles per channel; 0 treated as 1
//  sel         out SEL_WIDTH    to mux sel (registered)
//  clken       out 1            to mux clken; one-cycle pulse per switch
//  valid       out 1            mux dout belongs to chan_id this cycle
//  chan_id     out SEL_WIDTH    channel currently on mux dout
//  busy        out 1            high in any state except IDLE
//  sweep_done  out 1            one-cycle pulse after last enabled channel's dwell
//  cfg_err     out 1            one-cycle pulse: start with enable_mask == 0
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; config registers cleared.
//  States: IDLE -> SWITCH -> SETTLE -> DWELL -> (SWITCH | IDLE).
//  IDLE: start & mask!=0 & !stop -> latch mask/dwell/continuous; pick lowest enabled channel; -> SWITCH.
//        start & mask==0 -> cfg_err pulse next cycle; stay IDLE. Inputs are not sampled after start.
//  SWITCH (1 cycle): sel = target channel, clken = 1. Mux sel_reg updates at the end of this cycle.
//  SETTLE: lasts SETTLE_CYCLES cycles; clken = 0, valid = 0. sel is held.
//  DWELL: valid = 1, chan_id = sel, for max(dwell,1) cycles. The first DWELL cycle is the first one
//         in which the mux dout reflects the new channel (clken cycle k -> dout valid from k+1+SETTLE_CYCLES).
//  End of DWELL: next = next enabled channel above current, wrapping modulo N_INPUTS (rotate-priority).
//    Wrap past the highest enabled channel = sweep end: sweep_done pulses in the cycle after the last DWELL cycle.
//    continuous=0 -> IDLE; continuous=1 -> SWITCH to the lowest enabled channel.
//    Single enabled channel + continuous: re-enter SWITCH (clken re-pulses); sweep_done pulses every pass.
//  stop (any state): FSM -> IDLE on that edge; valid, clken and busy are 0 in the next cycle;
//    sel holds its last value; no sweep_done. Simultaneous start & stop in IDLE: stop wins.
//  start while busy: ignored. Config changes while busy: ignored until the next start.
//  Reset mid-scan: same as the reset state; the mux's sel_reg is not reset, so the next SWITCH rewrites it.
//  Dwell counter: DWELL_WIDTH bits, loads max(dwell,1)-1 and counts down to 0; no overflow possible.
//  Settle counter: $clog2(SETTLE_CYCLES+1) bits.
// STRUCTURE
//  Shared include mux_scan_defs.vh: FSM state localparams (IDLE, SWITCH, SETTLE, DWELL) and
//    the 2-cycle mux latency constant.
//  Sub-module rr_next_channel (combinational): inputs mask, current; outputs next, wrapped.
//    Used with current = N_INPUTS-1 to find the lowest enabled channel.
//  All other logic lives in this module: FSM, counters, output registers.
// TESTING (bench instantiates latched_mux with din = {32'hC, 32'hB, 32'hA})
//  1. mask=3'b111, dwell=4, continuous=0, start -> clken pulses with sel=0,1,2; valid 4 cycles each with
//     dout A,B,C matching chan_id; sweep_done once; busy falls.
//  2. mask=3'b101, dwell=2, continuous=1 -> channel order 0,2,0,2,...; sweep_done after each chan 2 dwell;
//     stop mid-DWELL -> valid=0 next cycle, no sweep_done.
//  3. mask=3'b000, start -> cfg_err pulse, busy stays 0, no clken.
//  4. dwell=0, mask=3'b010 -> exactly 1 valid cycle with dout=B; check clken-to-valid = 1+SETTLE_CYCLES cycles.
//  5. start & stop same cycle in IDLE -> stays IDLE. start while busy -> no restart, config unchanged.
//  6. resetn low during SETTLE -> all outputs 0 next cycle; new start scans correctly from channel lowest.

Source files
------------

// File: rtl/mux_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
// mux_scan_controller_pkg: FSM state encoding and mux timing shared by the scan block.
// Revision: 1.0
// ============================================================================
package mux_scan_controller_pkg;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_switch = 2'd1;
    localparam logic [1:0] c_st_settle = 2'd2;
    localparam logic [1:0] c_st_dwell  = 2'd3;

    // Latched mux: registered sel then registered dout
    localparam int c_mux_latency = 2;

endpackage
`default_nettype wire

// File: rtl/mux_scan_controller_rr_next_channel.sv
`default_nettype none
// ============================================================================
// rr_next_channel: next enabled channel strictly above current, wrapping to the lowest.
// Revision: 1.0
// ============================================================================
module rr_next_channel #(
    parameter int N_INPUTS  = 3,
    parameter int SEL_WIDTH = 2
) (
    input  logic [N_INPUTS-1:0]  mask,
    input  logic [SEL_WIDTH-1:0] current,
    output logic [SEL_WIDTH-1:0] next,
    output logic                 wrapped
);

    logic [SEL_WIDTH-1:0] w_lowest;
    logic [SEL_WIDTH-1:0] w_above;
    logic                 w_has_above;

    // Descending scans leave the lowest qualifying index in each result
    always_comb begin
        w_lowest    = current;
        w_above     = current;
        w_has_above = 1'b0;
        for (int i = N_INPUTS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                w_lowest = SEL_WIDTH'(i);
                if (i > int'(current)) begin
                    w_above     = SEL_WIDTH'(i);
                    w_has_above = 1'b1;
                end
            end
        end
        next    = w_has_above ? w_above : w_lowest;
        wrapped = ~w_has_above;
    end

endmodule
`default_nettype wire

// File: rtl/mux_scan_controller.sv
`default_nettype none
// ============================================================================
// mux_scan_controller: round-robin scan sequencer driving a latched N-input mux.
// Revision: 1.0
// ============================================================================
module mux_scan_controller
    import mux_scan_controller_pkg::*;
#(
    parameter int N_INPUTS      = 3,
    parameter int SEL_WIDTH     = 2,
    parameter int DWELL_WIDTH   = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   continuous,
    input  logic [N_INPUTS-1:0]    enable_mask,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [SEL_WIDTH-1:0]   sel,
    output logic                   clken,
    output logic                   valid,
    output logic [SEL_WIDTH-1:0]   chan_id,
    output logic                   busy,
    output logic                   sweep_done,
    output logic                   cfg_err
);

    localparam int c_settle_w  = $clog2(SETTLE_CYCLES + 1);
    // clken-to-valid lag; the SWITCH cycle covers the mux's own first stage
    localparam int c_dout_lag  = SETTLE_CYCLES + c_mux_latency - 1;
    localparam int c_settle_ld = c_dout_lag - c_mux_latency;

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [SEL_WIDTH-1:0]   r_sel;
    logic [SEL_WIDTH-1:0]   w_next_sel;
    logic [SEL_WIDTH-1:0]   r_chan_id;
    logic [N_INPUTS-1:0]    r_mask;
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic [DWELL_WIDTH-1:0] r_dwell_cnt;
    logic [c_settle_w-1:0]  r_settle_cnt;
    logic                   r_continuous;
    logic                   r_clken;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_sweep_done;
    logic                   r_cfg_err;
    logic [N_INPUTS-1:0]    w_rr_mask;
    logic [SEL_WIDTH-1:0]   w_rr_cur;
    logic [SEL_WIDTH-1:0]   w_rr_next;
    logic                   w_rr_wrapped;
    logic                   w_sweep_end;
    logic                   w_cfg_err;
    logic                   w_latch;

    // In IDLE, searching from the top channel yields the lowest enabled one
    assign w_rr_mask = (r_state == c_st_idle) ? enable_mask : r_mask;
    assign w_rr_cur  = (r_state == c_st_idle) ? SEL_WIDTH'(N_INPUTS - 1) : r_sel;

    rr_next_channel #(
        .N_INPUTS  (N_INPUTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr_next (
        .mask    (w_rr_mask),
        .current (w_rr_cur),
        .next    (w_rr_next),
        .wrapped (w_rr_wrapped)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_sel   = r_sel;
        w_sweep_end  = 1'b0;
        w_cfg_err    = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start && !stop) begin
                    if (enable_mask != '0) begin
                        w_latch      = 1'b1;
                        w_next_sel   = w_rr_next;
                        w_next_state = c_st_switch;
                    end else begin
                        w_cfg_err = 1'b1;
                    end
                end
            end
            c_st_switch: w_next_state = c_st_settle;
            c_st_settle: begin
                if (r_settle_cnt == '0) w_next_state = c_st_dwell;
            end
            c_st_dwell: begin
                if (r_dwell_cnt == '0) begin
                    w_sweep_end = w_rr_wrapped;
                    if (w_rr_wrapped && !r_continuous) begin
                        w_next_state = c_st_idle;
                    end else begin
                        w_next_sel   = w_rr_next;
                        w_next_state = c_st_switch;
                    end
                end
            end
            default: w_next_state = c_st_idle;
        endcase
        if (stop) begin
            w_next_state = c_st_idle;
            w_next_sel   = r_sel;
            w_sweep_end  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= c_st_idle;
            r_sel        <= '0;
            r_chan_id    <= '0;
            r_mask       <= '0;
            r_dwell      <= '0;
            r_dwell_cnt  <= '0;
            r_settle_cnt <= '0;
            r_continuous <= 1'b0;
            r_clken      <= 1'b0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_sweep_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_sel        <= w_next_sel;
            r_clken      <= (w_next_state == c_st_switch);
            r_valid      <= (w_next_state == c_st_dwell);
            r_busy       <= (w_next_state != c_st_idle);
            r_sweep_done <= w_sweep_end;
            r_cfg_err    <= w_cfg_err;
            if (w_next_state == c_st_dwell) r_chan_id <= w_next_sel;
            if (w_latch) begin
                r_mask       <= enable_mask;
                r_dwell      <= dwell;
                r_continuous <= continuous;
            end
            if (w_next_state == c_st_settle && r_state != c_st_settle) begin
                r_settle_cnt <= c_settle_w'(c_settle_ld);
            end else if (r_state == c_st_settle && r_settle_cnt != '0) begin
                r_settle_cnt <= r_settle_cnt - c_settle_w'(1);
            end
            // A dwell of 0 still yields one valid cycle
            if (w_next_state == c_st_dwell && r_state != c_st_dwell) begin
                r_dwell_cnt <= (r_dwell == '0) ? '0 : r_dwell - DWELL_WIDTH'(1);
            end else if (r_state == c_st_dwell && r_dwell_cnt != '0) begin
                r_dwell_cnt <= r_dwell_cnt - DWELL_WIDTH'(1);
            end
        end
    end

    assign sel        = r_sel;
    assign clken      = r_clken;
    assign valid      = r_valid;
    assign chan_id    = r_chan_id;
    assign busy       = r_busy;
    assign sweep_done = r_sweep_done;
    assign cfg_err    = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_controller.sv
`default_nettype none
// ============================================================================
// tb_mux_scan_controller: directed and randomized scans against a list-based trace model.
// Revision: 1.0
// ============================================================================
module tb_mux_scan_controller;

    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [2:0]  enable_mask;
    logic [15:0] dwell;
    logic [1:0]  sel;
    logic        clken;
    logic        valid;
    logic [1:0]  chan_id;
    logic        busy;
    logic        sweep_done;
    logic        cfg_err;

    always #5 clk = ~clk;

    mux_scan_controller #(
        .N_INPUTS      (3),
        .SEL_WIDTH     (2),
        .DWELL_WIDTH   (16),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .enable_mask (enable_mask),
        .dwell       (dwell),
        .sel         (sel),
        .clken       (clken),
        .valid       (valid),
        .chan_id     (chan_id),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .cfg_err     (cfg_err)
    );

    // Latched mux with din = {C, B, A}; sel_reg is deliberately never reset
    logic [31:0] din [4];
    logic [1:0]  mux_sel_reg = 2'd0;
    logic [31:0] mux_dout    = 32'd0;
    always @(posedge clk) begin
        if (clken) mux_sel_reg <= sel;
        mux_dout <= din[mux_sel_reg];
    end

    typedef struct packed {
        logic       clken;
        logic [1:0] sel;
        logic       valid;
        logic [1:0] chan;
        logic       sweep_done;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected per-cycle outputs, cycle 1 = first cycle after the start edge
    function automatic void build_trace(input logic [2:0] mask, input int dw, input bit cont,
                                        input int min_len);
        int   d       = (dw == 0) ? 1 : dw;
        bit   pending = 1'b0;
        exp_t e;
        exp_q.delete();
        while (1) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (mask[ch]) begin
                    e = '0; e.clken = 1'b1; e.sel = 2'(ch); e.busy = 1'b1; e.sweep_done = pending;
                    pending = 1'b0;
                    exp_q.push_back(e);
                    for (int s = 0; s < SETTLE; s++) begin
                        e = '0; e.busy = 1'b1;
                        exp_q.push_back(e);
                    end
                    for (int k = 0; k < d; k++) begin
                        e = '0; e.valid = 1'b1; e.chan = 2'(ch); e.busy = 1'b1;
                        exp_q.push_back(e);
                    end
                end
            end
            pending = 1'b1;
            if (!cont || exp_q.size() >= min_len) break;
        end
        if (!cont) begin
            e = '0; e.sweep_done = 1'b1;
            exp_q.push_back(e);
        end
    endfunction

    task automatic check_idle(input string tag, input logic [1:0] exp_sel);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " idle valid"}, 32'(valid), 32'd0);
        chk({tag, " idle clken"}, 32'(clken), 32'd0);
        chk({tag, " idle sweep_done"}, 32'(sweep_done), 32'd0);
        chk({tag, " idle sel"}, 32'(sel), 32'(exp_sel));
    endtask

    task automatic run_scan(input string name, input logic [2:0] mask, input logic [15:0] dw,
                            input bit cont, input int stop_at, input int poke_at);
        logic [1:0] last_sel;
        exp_t       e;
        string      t;
        last_sel = sel;
        build_trace(mask, int'(dw), cont, (stop_at > 0) ? stop_at : 1);
        if (cont && stop_at == 0) stop_at = exp_q.size();
        enable_mask = mask; dwell = dw; continuous = cont; start = 1'b1;
        tick();
        start = 1'b0;
        enable_mask = 3'($urandom); dwell = 16'($urandom); continuous = 1'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            t = $sformatf("%s c%0d", name, i + 1);
            chk({t, " clken"}, 32'(clken), 32'(e.clken));
            chk({t, " busy"}, 32'(busy), 32'(e.busy));
            chk({t, " valid"}, 32'(valid), 32'(e.valid));
            chk({t, " sweep_done"}, 32'(sweep_done), 32'(e.sweep_done));
            if (e.clken) begin
                chk({t, " sel"}, 32'(sel), 32'(e.sel));
                last_sel = e.sel;
            end
            if (e.valid) begin
                chk({t, " chan_id"}, 32'(chan_id), 32'(e.chan));
                chk({t, " dout"}, mux_dout, din[e.chan]);
            end
            if (i + 1 == poke_at && e.busy) start = 1'b1;
            if (i + 1 == stop_at) begin
                stop = 1'b1;
                tick();
                stop = 1'b0; start = 1'b0;
                check_idle({name, " stop"}, last_sel);
                return;
            end
            tick();
            start = 1'b0;
        end
        check_idle({name, " end"}, last_sel);
    endtask

    initial begin
        din[0] = 32'hA; din[1] = 32'hB; din[2] = 32'hC; din[3] = 32'h0;
        resetn = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        enable_mask = 3'b000; dwell = 16'd0;
        repeat (3) tick();
        chk("reset sel", 32'(sel), 32'd0);
        chk("reset clken", 32'(clken), 32'd0);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset chan_id", 32'(chan_id), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset sweep_done", 32'(sweep_done), 32'd0);
        chk("reset cfg_err", 32'(cfg_err), 32'd0);
        resetn = 1'b1;
        tick();

        // Full sweep, one-shot; start re-pulsed mid-scan must be ignored
        run_scan("t1", 3'b111, 16'd4, 1'b0, 0, 5);
        // Channels 0,2 continuous; stop in the first dwell cycle of channel 2, second pass
        run_scan("t2", 3'b101, 16'd2, 1'b1, 15, 0);

        enable_mask = 3'b000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3 cfg_err", 32'(cfg_err), 32'd1);
        chk("t3 busy", 32'(busy), 32'd0);
        chk("t3 clken", 32'(clken), 32'd0);
        tick();
        chk("t3 cfg_err drop", 32'(cfg_err), 32'd0);
        chk("t3 busy after", 32'(busy), 32'd0);

        // dwell 0 on channel 1 only: a single valid cycle with B
        run_scan("t4", 3'b010, 16'd0, 1'b0, 0, 0);

        enable_mask = 3'b111; dwell = 16'd2; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("t5 busy", 32'(busy), 32'd0);
        chk("t5 clken", 32'(clken), 32'd0);
        chk("t5 cfg_err", 32'(cfg_err), 32'd0);
        tick();
        chk("t5 busy later", 32'(busy), 32'd0);

        enable_mask = 3'b110; dwell = 16'd3; continuous = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6 switch sel", 32'(sel), 32'd1);
        tick();
        chk("t6 settle busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        tick();
        chk("t6 reset sel", 32'(sel), 32'd0);
        chk("t6 reset clken", 32'(clken), 32'd0);
        chk("t6 reset valid", 32'(valid), 32'd0);
        chk("t6 reset chan_id", 32'(chan_id), 32'd0);
        chk("t6 reset busy", 32'(busy), 32'd0);
        chk("t6 reset sweep_done", 32'(sweep_done), 32'd0);
        chk("t6 reset cfg_err", 32'(cfg_err), 32'd0);
        resetn = 1'b1;
        run_scan("t6", 3'b111, 16'd1, 1'b0, 0, 0);

        for (int r = 0; r < 10; r++) begin
            logic [2:0]  m;
            logic [15:0] d;
            bit          c;
            int          s;
            m = 3'($urandom_range(1, 7));
            d = 16'($urandom_range(0, 4));
            c = 1'($urandom_range(0, 1));
            if (c) s = $urandom_range(1, 30);
            else   s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
            run_scan($sformatf("rnd%0d", r), m, d, c, s, $urandom_range(1, 20));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
